// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage with IF/ID register; one outstanding I-cache request.
// Optional build macro FETCH_FLUSH_NOP_EN: redirects/bubbles also write NOP (and pc 0 on redirect).
//
// state  | meaning
// S_REQ  | presenting a fetch request at pc
// S_WAIT | request accepted, waiting for the response
// S_HOLD | response parked in hold register while decode is stalled
// S_DROP | wrong-path response still in flight; discard it on arrival
module fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    output logic            o_ifid_valid,
    output logic [XLEN-1:0] o_ifid_pc,
    output logic [XLEN-1:0] o_ifid_instr
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic            handshake;

    assign o_imem_req_valid = (state_q == S_REQ) & ~i_redirect & ~i_rst;
    assign o_imem_req_addr  = pc_q;
    assign handshake        = o_imem_req_valid & i_imem_req_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_instr = hold_q;
        case (state_q)
            S_REQ: begin
                if (i_redirect) begin
                    pc_d = i_redirect_pc;
                end else if (handshake) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rsp_valid) begin
                    if (i_redirect) begin
                        pc_d    = i_redirect_pc;
                        state_d = S_REQ;
                    end else if (i_stall) begin
                        hold_d  = i_imem_rsp_data;
                        state_d = S_HOLD;
                    end else begin
                        load       = 1'b1;
                        load_instr = i_imem_rsp_data;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_REQ;
                    end
                end else if (i_redirect) begin
                    pc_d    = i_redirect_pc;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                // The redirect target must still be taken even though the parked word is dropped.
                if (i_redirect) begin
                    pc_d    = i_redirect_pc;
                    state_d = S_REQ;
                end else if (!i_stall) begin
                    load    = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (i_redirect) begin
                    pc_d = i_redirect_pc;
                end
                if (i_imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Priority: redirect flushes even under stall, then stall freezes, then load, else bubble.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (i_redirect) begin
            ifid_valid_d = 1'b0;
`ifdef FETCH_FLUSH_NOP_EN
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
`endif
        end else if (i_stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (load) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = load_instr;
        end else begin
            ifid_valid_d = 1'b0;
`ifdef FETCH_FLUSH_NOP_EN
            ifid_instr_d = NOP_INSTR;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            hold_q       <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign o_ifid_valid = ifid_valid_q;
    assign o_ifid_pc    = ifid_pc_q;
    assign o_ifid_instr = ifid_instr_q;

endmodule
